// File: rtl/player_knife_if.sv
// Play-field bundle between the player knife block and its surroundings.
// Pure wiring; no latency of its own.
// No backpressure: every field is a frame-rate level signal.
interface player_knife_if;
    logic [3:0] game_state;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       throw_key;
    logic [9:0] monsterX;
    logic [9:0] monsterY;
    logic       monster_exist;
    logic [9:0] fireballX;
    logic [9:0] fireballY;
    logic [9:0] fireballS;
    logic       fireball_exist;
    logic [9:0] knifeX;
    logic [9:0] knifeY;
    logic       knife_exist;
    logic       knife_hit;
    logic [5:0] player_life_value;
    logic       player_dead;

    // Game / HUD side: drives player, monster and fireball state, observes the knife and health
    modport master (
        output game_state, BallX, BallY, BallS, throw_key,
               monsterX, monsterY, monster_exist,
               fireballX, fireballY, fireballS, fireball_exist,
        input  knifeX, knifeY, knife_exist, knife_hit, player_life_value, player_dead
    );

    // Knife block side
    modport slave (
        input  game_state, BallX, BallY, BallS, throw_key,
               monsterX, monsterY, monster_exist,
               fireballX, fireballY, fireballS, fireball_exist,
        output knifeX, knifeY, knife_exist, knife_hit, player_life_value, player_dead
    );
endinterface

// File: rtl/player_knife.sv
// Player knife launcher (IDLE/FLYING/COOLDOWN) plus fireball-vs-player health scoring.
// Latency: every output is registered; inputs take effect on the next frame_clk edge.
// No backpressure; optional homing flight enabled by defining PLAYER_KNIFE_HOMING_EN.
module player_knife #(
    parameter int KNIFE_STEP      = 4,
    parameter int RIGHT_EDGE      = 639,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int PLAYER_LIFE     = 5,
    parameter int INVULN_FRAMES   = 30
) (
    input  logic          frame_clk,
    input  logic          Reset_n,
    player_knife_if.slave bus
);

    localparam logic [10:0] STEP      = 11'(KNIFE_STEP);
    localparam logic [9:0]  EDGE_X    = 10'(RIGHT_EDGE);
    localparam logic [7:0]  CD_LAST   = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [5:0]  LIFE_INIT = 6'(PLAYER_LIFE);
    localparam logic [7:0]  INV_LOAD  = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  knife_x;
    logic [9:0]  knife_y;
    logic        knife_exist;
    logic        knife_hit;
    logic [7:0]  cd_cnt;
    logic [5:0]  life;
    logic        dead;
    logic [7:0]  inv_cnt;
    logic        throw_d;

    logic        play;
    logic        trig;
    logic        in_win;
    logic        fb_hit;
    logic        kill;

    logic signed [11:0] kx, ky, mx, my;
    logic signed [11:0] dx, dy;
    logic        [11:0] adx, ady, reach;

    // Position add that clamps at the right edge of the 10-bit coordinate space
    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [10:0] b);
        logic [11:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > 12'd1023) ? 10'd1023 : s[9:0];
    endfunction

    assign play = (bus.game_state == 4'd2);
    assign trig = bus.throw_key & ~throw_d;

    // Signed window and distance math so small coordinates never wrap
    always_comb begin
        kx    = $signed({2'b00, knife_x});
        ky    = $signed({2'b00, knife_y});
        mx    = $signed({2'b00, bus.monsterX});
        my    = $signed({2'b00, bus.monsterY});
        dx    = $signed({2'b00, bus.fireballX}) - $signed({2'b00, bus.BallX});
        dy    = $signed({2'b00, bus.fireballY}) - $signed({2'b00, bus.BallY});
        adx   = dx[11] ? $unsigned(-dx) : $unsigned(dx);
        ady   = dy[11] ? $unsigned(-dy) : $unsigned(dy);
        reach = {2'b00, bus.BallS} + {2'b00, bus.fireballS};

        in_win = bus.monster_exist &&
                 (kx >= mx - 12'sd2)  && (kx <= mx + 12'sd3) &&
                 (ky >= my - 12'sd30) && (ky <= my + 12'sd30);

        fb_hit = play && bus.fireball_exist && (inv_cnt == 8'd0) &&
                 !dead && (life != 6'd0) && (adx <= reach) && (ady <= reach);
        kill   = fb_hit && (life == 6'd1);
    end

    // Previous throw_key level for edge detection; tracked even outside play so a held key never fires
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            throw_d <= 1'b0;
        end else begin
            throw_d <= bus.throw_key;
        end
    end

    // Health and post-hit immunity
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            life    <= LIFE_INIT;
            dead    <= 1'b0;
            inv_cnt <= 8'd0;
        end else if (!play) begin
            life    <= LIFE_INIT;
            dead    <= 1'b0;
            inv_cnt <= 8'd0;
        end else if (fb_hit) begin
            inv_cnt <= INV_LOAD;
            if (kill) begin
                life <= 6'd0;
                dead <= 1'b1;
            end else begin
                life <= life - 6'd1;
            end
        end else if (inv_cnt != 8'd0) begin
            inv_cnt <= inv_cnt - 8'd1;
        end
    end

    // Knife FSM with registered position, flight flag and hit pulse
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            knife_x     <= 10'd0;
            knife_y     <= 10'd0;
            knife_exist <= 1'b0;
            knife_hit   <= 1'b0;
            cd_cnt      <= 8'd0;
        end else if (!play || dead || kill) begin
            // Out of play or dead: park on the player; a fatal hit also cancels a same-frame throw
            state       <= IDLE;
            knife_x     <= bus.BallX;
            knife_y     <= bus.BallY;
            knife_exist <= 1'b0;
            knife_hit   <= 1'b0;
            cd_cnt      <= 8'd0;
        end else begin
            knife_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state       <= FLYING;
                        knife_x     <= sat_add(bus.BallX, {1'b0, bus.BallS});
                        knife_y     <= bus.BallY;
                        knife_exist <= 1'b1;
                    end else begin
                        knife_x     <= bus.BallX;
                        knife_y     <= bus.BallY;
                        knife_exist <= 1'b0;
                    end
                end
                FLYING: begin
                    // Hit test on the position currently presented; a hit wins over the edge
                    if (in_win || (knife_x >= EDGE_X)) begin
                        state       <= COOLDOWN;
                        knife_hit   <= in_win;
                        knife_exist <= 1'b0;
                        knife_x     <= bus.BallX;
                        knife_y     <= bus.BallY;
                        cd_cnt      <= 8'd0;
                    end else begin
                        knife_x <= sat_add(knife_x, STEP);
`ifdef PLAYER_KNIFE_HOMING_EN
                        if (bus.monster_exist) begin
                            if (knife_y < bus.monsterY) begin
                                knife_y <= knife_y + 10'd1;
                            end else if (knife_y > bus.monsterY) begin
                                knife_y <= knife_y - 10'd1;
                            end
                        end
`endif
                    end
                end
                COOLDOWN: begin
                    // Triggers are simply ignored here, so nothing is queued for later
                    knife_x     <= bus.BallX;
                    knife_y     <= bus.BallY;
                    knife_exist <= 1'b0;
                    if (cd_cnt == CD_LAST) begin
                        state  <= IDLE;
                        cd_cnt <= 8'd0;
                    end else begin
                        cd_cnt <= cd_cnt + 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    knife_exist <= 1'b0;
                end
            endcase
        end
    end

    assign bus.knifeX            = knife_x;
    assign bus.knifeY            = knife_y;
    assign bus.knife_exist       = knife_exist;
    assign bus.knife_hit         = knife_hit;
    assign bus.player_life_value = life;
    assign bus.player_dead       = dead;

endmodule
